// File: rtl/exram_pkg.sv
// Shared encodings for the external RAM arbiter: FSM states, grant codes and
// the wait-counter width helper.
package exram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF   = 2'd1;
  localparam logic [1:0] GNT_MEM  = 2'd2;
  localparam logic [1:0] GNT_LD   = 2'd3;

  // A single-cycle access still needs a 1-bit counter to hold the zero value.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/exram_wait_counter.sv
// Loadable down-counter that times one RAM access; it saturates at zero and
// only restarts when the arbiter reloads it from IDLE.
module exram_wait_counter
  import exram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic clrn,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    // NOTE: assign the default first so every path drives cnt_d; a missing
    // branch in combinational logic would otherwise infer a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/exram_arbiter.sv
// Single-port external RAM arbiter: fixed priority loader > MEM > IF, one
// access per WAIT_CYCLES+2 cycles, registered read data and ready pulses.
module exram_arbiter
  import exram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              ld_ready_q, ld_ready_d;
  logic              any_req;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;

  assign any_req  = if_req | mem_req | ld_req;
  assign cnt_load = (state_q == ST_IDLE) && any_req;
  assign cnt_en   = (state_q == ST_BUSY);

  exram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .clrn(clrn),
    .load(cnt_load),
    .en  (cnt_en),
    .zero(cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    ld_ready_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The whole request is captured here; requester inputs are ignored
        // until the next IDLE cycle.
        if (ld_req) begin
          state_d = ST_BUSY;
          gnt_d   = GNT_LD;
          we_d    = 1'b1;
          addr_d  = ld_addr;
          wdata_d = ld_wdata;
        end else if (mem_req) begin
          state_d = ST_BUSY;
          gnt_d   = GNT_MEM;
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (if_req) begin
          state_d = ST_BUSY;
          gnt_d   = GNT_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
        end
      end
      ST_BUSY: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
          unique case (gnt_q)
            GNT_IF: begin
              if_rdata_d = ram_rdata;
              if_ready_d = 1'b1;
            end
            GNT_MEM: begin
              if (!we_q) mem_rdata_d = ram_rdata;
              mem_ready_d = 1'b1;
            end
            GNT_LD:  ld_ready_d = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ld_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      ld_ready_q  <= ld_ready_d;
    end
  end

  // RAM strobes decode straight from state so a reset drops them at once.
  assign ram_ena   = (state_q == ST_BUSY);
  assign ram_wena  = ram_ena & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign ld_ready  = ld_ready_q;

endmodule

// File: tb/tb_exram_arbiter.sv
// Scoreboard bench for exram_arbiter: a priority/timing model predicts each
// ready pulse and RAM cycle; a monitor compares whatever the DUT presents.
module tb_exram_arbiter;
  import exram_pkg::*;

  localparam int W = 2;

  typedef struct {
    logic [1:0]  who;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
  } exp_t;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req, mem_req, mem_we, ld_req;
  logic [31:0] if_addr, mem_addr, mem_wdata, ld_addr, ld_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, ld_ready, ram_ena, ram_wena, busy;

  logic        if_req1, zero1;
  logic [31:0] if_addr1, zero32;
  logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic        if_ready1, mem_ready1, ld_ready1, ram_ena1, ram_wena1, busy1;

  exram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  exram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .clk(clk), .clrn(clrn),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .mem_req(zero1), .mem_we(zero1), .mem_addr(zero32), .mem_wdata(zero32),
    .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
    .ld_req(zero1), .ld_addr(zero32), .ld_wdata(zero32), .ld_ready(ld_ready1),
    .ram_ena(ram_ena1), .ram_wena(ram_wena1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .busy(busy1)
  );

  // External RAM the DUTs talk to, and the reference copy the model updates.
  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  assign ram_rdata  = ram_mem[ram_addr[9:2]];
  assign ram_rdata1 = ram_mem[ram_addr1[9:2]];
  always @(posedge clk) if (ram_ena && ram_wena) ram_mem[ram_addr[9:2]] <= ram_wdata;

  int n_checks = 0;
  int n_err = 0;
  exp_t sb_q[$];
  bit sb_on = 1'b0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_mem_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  // Monitor: compares RAM cycles and ready pulses against the queue head.
  int ena_cnt = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    int nrdy;
    logic [1:0] who;
    if (sb_on) begin
      nrdy = int'(if_ready) + int'(mem_ready) + int'(ld_ready);
      if (nrdy > 1) check("ready_onehot", 32'(nrdy), 32'd1);
      if (ram_ena) begin
        ena_cnt++;
        if (sb_q.size() == 0) begin
          check("ram_ena_unexpected", 32'(ram_ena), 32'd0);
        end else begin
          check("ram_addr", ram_addr, sb_q[0].addr);
          check("ram_wena", 32'(ram_wena), 32'(sb_q[0].we));
          if (sb_q[0].we) check("ram_wdata", ram_wdata, sb_q[0].wdata);
        end
      end else begin
        check("ram_wena_idle", 32'(ram_wena), 32'd0);
      end
      if (nrdy != 0) begin
        if (sb_q.size() == 0) begin
          check("ready_unexpected", 32'(nrdy), 32'd0);
        end else begin
          e = sb_q.pop_front();
          who = ld_ready ? GNT_LD : (mem_ready ? GNT_MEM : GNT_IF);
          check("ready_who", 32'(who), 32'(e.who));
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("if_rdata", if_rdata, e.if_rd);
          check("mem_rdata", mem_rdata, e.mem_rd);
          check("ena_cycles", 32'(ena_cnt), 32'(W));
          check("busy_in_resp", 32'(busy), 32'd1);
          ena_cnt = 0;
        end
      end
    end
  end

  // One arbitration round; called just after a rising edge with the DUT idle.
  task automatic run_round(input bit a_ld, input bit a_mem, input bit a_if, input bit drop);
    logic [1:0] order [3] = '{GNT_LD, GNT_MEM, GNT_IF};
    int start = cyc;
    int k = 0;
    int guard = 0;
    int pending;
    bit d_ld = 0, d_mem = 0, d_if = 0;
    logic [1:0] first;
    exp_t e;
    first = a_ld ? GNT_LD : (a_mem ? GNT_MEM : GNT_IF);
    for (int p = 0; p < 3; p++) begin
      bit act;
      act = (order[p] == GNT_LD) ? a_ld : (order[p] == GNT_MEM) ? a_mem : a_if;
      if (!act) continue;
      e.who = order[p];
      e.cyc = start + (k + 1) * (W + 2) - 1;
      k++;
      case (order[p])
        GNT_LD:  begin e.addr = ld_addr;  e.we = 1'b1;   e.wdata = ld_wdata;  end
        GNT_MEM: begin e.addr = mem_addr; e.we = mem_we; e.wdata = mem_wdata; end
        default: begin e.addr = if_addr;  e.we = 1'b0;   e.wdata = '0;        end
      endcase
      if (e.we) ref_mem[e.addr[9:2]] = e.wdata;
      else if (order[p] == GNT_IF) exp_if_rd = ref_mem[e.addr[9:2]];
      else exp_mem_rd = ref_mem[e.addr[9:2]];
      e.if_rd = exp_if_rd;
      e.mem_rd = exp_mem_rd;
      sb_q.push_back(e);
    end
    pending = k;
    ld_req = a_ld;
    mem_req = a_mem;
    if_req = a_if;
    while (pending > 0 && guard < 100) begin
      @(negedge clk);
      if (guard == 0) begin
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ram_ena", 32'(ram_ena), 32'd0);
      end
      if (ld_ready)  begin d_ld = 1;  pending--; end
      if (mem_ready) begin d_mem = 1; pending--; end
      if (if_ready)  begin d_if = 1;  pending--; end
      @(posedge clk); #1;
      guard++;
      if (d_ld) ld_req = 1'b0;
      if (d_mem) mem_req = 1'b0;
      if (d_if) if_req = 1'b0;
      if (drop && cyc == start + 2) begin
        case (first)
          GNT_LD:  begin ld_req = 1'b0; ld_addr = $urandom; ld_wdata = $urandom; end
          GNT_MEM: begin
            mem_req = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_we = ~mem_we;
          end
          default: begin if_req = 1'b0; if_addr = $urandom; end
        endcase
      end
    end
    if (pending > 0) check("round_timeout", 32'(pending), 32'd0);
    ld_req = 1'b0;
    mem_req = 1'b0;
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, rdy_cyc, k, ena1;
    logic [31:0] rd, a;
    logic [31:0] addrs1 [4];
    bit got;
    clrn = 1'b0;
    {if_req, mem_req, mem_we, ld_req} = '0;
    {if_addr, mem_addr, mem_wdata, ld_addr, ld_wdata} = '0;
    if_req1 = 1'b0; if_addr1 = '0; zero1 = 1'b0; zero32 = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_ena", 32'(ram_ena), 32'd0);
    check("rst_ram_wena", 32'(ram_wena), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    @(negedge clk) clrn = 1'b1;
    @(posedge clk); #1;
    sb_on = 1'b1;

    // Single fetch, store, three-way contention, early drop.
    ram_mem[16] = 32'h2408_0005;
    ref_mem[16] = 32'h2408_0005;
    if_addr = 32'h0000_0040;
    run_round(0, 0, 1, 0);
    mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    run_round(0, 1, 0, 0);
    ld_addr = rand_addr(); ld_wdata = $urandom;
    mem_we = 1'b0; mem_addr = rand_addr(); if_addr = rand_addr();
    run_round(1, 1, 1, 0);
    mem_we = 1'b0; mem_addr = rand_addr(); if_addr = rand_addr();
    run_round(0, 1, 1, 1);

    repeat (40) begin
      int sel;
      sel = $urandom_range(1, 7);
      ld_addr = rand_addr(); ld_wdata = $urandom;
      mem_addr = rand_addr(); mem_wdata = $urandom; mem_we = 1'($urandom_range(0, 1));
      if_addr = rand_addr();
      run_round(sel[2], sel[1], sel[0], 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    // Reset in the middle of a fetch, then a normal re-arbitration.
    @(posedge clk); #1;
    s = cyc;
    a = rand_addr();
    if_addr = a;
    if_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clrn = 1'b0;
    #1;
    check("midrst_ram_ena", 32'(ram_ena), 32'd0);
    check("midrst_ram_wena", 32'(ram_wena), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_if_ready", 32'(if_ready), 32'd0);
    check("midrst_ram_addr", ram_addr, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    @(negedge clk) clrn = 1'b1;
    rdy_cyc = -1;
    rd = '0;
    for (int i = 0; i < 12 && rdy_cyc < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (if_ready) begin
        rdy_cyc = cyc;
        rd = if_rdata;
      end
    end
    check("midrst_refetch_cycle", 32'(rdy_cyc), 32'(s + 2 + W + 1));
    check("midrst_refetch_data", rd, ref_mem[a[9:2]]);
    @(posedge clk); #1;
    if_req = 1'b0;

    // WAIT_CYCLES=1 instance: back-to-back fetches every three cycles.
    for (int i = 0; i < 4; i++) addrs1[i] = rand_addr();
    @(posedge clk); #1;
    s = cyc;
    k = 0;
    ena1 = 0;
    if_addr1 = addrs1[0];
    if_req1 = 1'b1;
    for (int i = 0; i < 30 && k < 4; i++) begin
      @(negedge clk);
      got = 1'b0;
      if (ram_ena1) ena1++;
      if (if_ready1) begin
        check("w1_ready_cycle", 32'(cyc), 32'(s + 2 + 3 * k));
        check("w1_rdata", if_rdata1, ref_mem[addrs1[k][9:2]]);
        check("w1_ena_cycles", 32'(ena1), 32'd1);
        ena1 = 0;
        k++;
        got = 1'b1;
      end
      @(posedge clk); #1;
      if (got) begin
        if (k == 4) if_req1 = 1'b0;
        else if_addr1 = addrs1[k];
      end
    end
    check("w1_accesses", 32'(k), 32'd4);
    if_req1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
